fetch_unit: RTL and testbench

Instruction-fetch stage of the single-issue RISC-V core. It owns the program counter and drives the instruction memory read address. It captures the returned instruction into the IF/ID pipeline register consumed by decode. It handles reset start-up, stalls, flushes and branch/jump redirects, and keeps a fetch counter for performance monitoring.

---
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, drives the instruction
// memory address and captures the returned word into the IF/ID register.
// Handles the BOOT start-up cycle, stalls, flushes and redirects, and keeps
// a counter of valid instructions delivered to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_inst_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_inst_o,
    output logic        misalign_o,
    output logic        range_err_o,
    output logic [31:0] fetch_count_o
);

    typedef enum logic {BOOT, RUN} state_e;

    // One IF/ID pipeline entry as consumed by decode.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
    } if_id_t;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    if_id_t      if_id_q, if_id_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    logic [31:0] pc_plus4;
    if_id_t      bubble;
    if_id_t      fetched;

    assign pc_plus4 = pc_q + 32'd4;

    // Bubble still records the PC it replaced so debug/trace sees where it sat.
    assign bubble  = '{valid: 1'b0, pc: pc_q, pc4: pc_plus4, inst: NOP_INST};
    assign fetched = '{valid: 1'b1, pc: pc_q, pc4: pc_plus4, inst: imem_inst_i};

    // Next-state logic: FSM, next PC, IF/ID load, misalign pulse, fetch count.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        if_id_d     = if_id_q;
        misalign_d  = 1'b0;
        fetch_cnt_d = fetch_cnt_q;

        unique case (state_q)
            BOOT: begin
                // Hold PC so the first fetch is presented for a full cycle.
                state_d = RUN;
                if_id_d = bubble;
            end
            RUN: begin
                // Next PC: redirect beats stall beats sequential advance.
                if (redirect_valid_i) begin
                    pc_d       = redirect_pc_i & ~32'h3;
                    misalign_d = |redirect_pc_i[1:0];
                end else if (!stall_i) begin
                    pc_d = pc_plus4;
                end

                // IF/ID: a kill beats a stall beats a normal load.
                if (redirect_valid_i || flush_i) begin
                    if_id_d = bubble;
                end else if (!stall_i) begin
                    if_id_d     = fetched;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            if_id_q     <= '{valid: 1'b0, pc: 32'd0, pc4: 32'd4, inst: NOP_INST};
            misalign_q  <= 1'b0;
            fetch_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_id_q     <= if_id_d;
            misalign_q  <= misalign_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign if_id_valid_o = if_id_q.valid;
    assign if_id_pc_o    = if_id_q.pc;
    assign if_id_pc4_o   = if_id_q.pc4;
    assign if_id_inst_o  = if_id_q.inst;
    assign misalign_o    = misalign_q;
    assign fetch_count_o = fetch_cnt_q;

    // Word index compared at full width so large PCs never alias.
    assign range_err_o = ({2'b00, pc_q[31:2]} >= 32'(IMEM_WORDS));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. Instruction memory returns
// 32'h1000_0000 + word index for any address.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, flush, redir_v;
    logic [31:0] redir_pc;
    logic [31:0] imem_addr, imem_inst;
    logic        v, misalign, range_err;
    logic [31:0] ipc, ipc4, iinst, fcnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign imem_inst = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

    fetch_unit dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .stall_i          (stall),
        .flush_i          (flush),
        .redirect_valid_i (redir_v),
        .redirect_pc_i    (redir_pc),
        .imem_addr_o      (imem_addr),
        .imem_inst_i      (imem_inst),
        .if_id_valid_o    (v),
        .if_id_pc_o       (ipc),
        .if_id_pc4_o      (ipc4),
        .if_id_inst_o     (iinst),
        .misalign_o       (misalign),
        .range_err_o      (range_err),
        .fetch_count_o    (fcnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redir_v = 1'b0; redir_pc = '0;
        tick(); tick();
        // Reset values
        chk("rst_valid", 32'(v), 32'd0);
        chk("rst_inst", iinst, 32'h13);
        chk("rst_pc", ipc, 32'd0);
        chk("rst_pc4", ipc4, 32'd4);
        chk("rst_mis", 32'(misalign), 32'd0);
        chk("rst_cnt", fcnt, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_rerr", 32'(range_err), 32'd0);

        // BOOT edge: bubble, PC held
        rst = 1'b0;
        tick();
        chk("boot_valid", 32'(v), 32'd0);
        chk("boot_addr", imem_addr, 32'd0);
        chk("boot_inst", iinst, 32'h13);
        // First valid fetch
        tick();
        chk("f0_valid", 32'(v), 32'd1);
        chk("f0_pc", ipc, 32'd0);
        chk("f0_inst", iinst, 32'h1000_0000);
        chk("f0_addr", imem_addr, 32'd4);
        tick();
        chk("f1_pc", ipc, 32'd4);
        chk("f1_inst", iinst, 32'h1000_0001);
        chk("f1_addr", imem_addr, 32'd8);
        chk("f1_cnt", fcnt, 32'd2);

        // Stall 3 cycles at pc=8
        stall = 1'b1;
        tick(); tick(); tick();
        chk("stl_addr", imem_addr, 32'd8);
        chk("stl_pc", ipc, 32'd4);
        chk("stl_inst", iinst, 32'h1000_0001);
        chk("stl_cnt", fcnt, 32'd2);
        stall = 1'b0;
        tick();
        chk("rel_pc", ipc, 32'd8);
        chk("rel_inst", iinst, 32'h1000_0002);
        chk("rel_addr", imem_addr, 32'd12);
        chk("rel_cnt", fcnt, 32'd3);

        // Redirect to 0x100 while pc=12
        redir_v = 1'b1; redir_pc = 32'h100;
        tick();
        redir_v = 1'b0;
        chk("rd_addr", imem_addr, 32'h100);
        chk("rd_valid", 32'(v), 32'd0);
        chk("rd_inst", iinst, 32'h13);
        chk("rd_bpc", ipc, 32'd12);
        chk("rd_cnt", fcnt, 32'd3);
        chk("rd_mis", 32'(misalign), 32'd0);
        tick();
        chk("rt_valid", 32'(v), 32'd1);
        chk("rt_pc", ipc, 32'h100);
        chk("rt_inst", iinst, 32'h1000_0040);
        chk("rt_cnt", fcnt, 32'd4);

        // Misaligned redirect to 0x102 with stall
        redir_v = 1'b1; redir_pc = 32'h102; stall = 1'b1;
        tick();
        redir_v = 1'b0; stall = 1'b0;
        chk("ma_addr", imem_addr, 32'h100);
        chk("ma_mis", 32'(misalign), 32'd1);
        chk("ma_valid", 32'(v), 32'd0);
        tick();
        chk("ma_mis_off", 32'(misalign), 32'd0);
        chk("ma_pc", ipc, 32'h100);
        chk("ma_cnt", fcnt, 32'd5);

        // Flush alone at pc=0x20
        redir_v = 1'b1; redir_pc = 32'h20;
        tick();
        redir_v = 1'b0;
        chk("fl_pre_addr", imem_addr, 32'h20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(v), 32'd0);
        chk("fl_addr", imem_addr, 32'h24);
        chk("fl_cnt", fcnt, 32'd5);
        tick();
        chk("fl_next_pc", ipc, 32'h24);
        chk("fl_next_cnt", fcnt, 32'd6);

        // Flush with stall: bubble, PC holds
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        chk("fs_valid", 32'(v), 32'd0);
        chk("fs_addr", imem_addr, 32'h28);

        // Wrap at top of address space
        redir_v = 1'b1; redir_pc = 32'hFFFF_FFFC;
        tick();
        redir_v = 1'b0;
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wr_rerr", 32'(range_err), 32'd1);
        tick();
        chk("wr_next", imem_addr, 32'd0);
        chk("wr_pc", ipc, 32'hFFFF_FFFC);
        chk("wr_pc4", ipc4, 32'd0);
        chk("wr_rerr0", 32'(range_err), 32'd0);

        // Range boundary: last word in range, then first out of range
        redir_v = 1'b1; redir_pc = 32'hFFC;
        tick();
        redir_v = 1'b0;
        chk("rg_last", 32'(range_err), 32'd0);
        tick();
        chk("rg_addr", imem_addr, 32'h1000);
        chk("rg_first", 32'(range_err), 32'd1);

        // Reset mid-run with a misaligned redirect pending
        redir_v = 1'b1; redir_pc = 32'h203;
        rst = 1'b1;
        tick();
        redir_v = 1'b0;
        chk("mr_valid", 32'(v), 32'd0);
        chk("mr_inst", iinst, 32'h13);
        chk("mr_pc", ipc, 32'd0);
        chk("mr_pc4", ipc4, 32'd4);
        chk("mr_mis", 32'(misalign), 32'd0);
        chk("mr_cnt", fcnt, 32'd0);
        chk("mr_addr", imem_addr, 32'd0);
        rst = 1'b0;
        tick();
        chk("mr_boot", 32'(v), 32'd0);
        tick();
        chk("mr_f0_valid", 32'(v), 32'd1);
        chk("mr_f0_inst", iinst, 32'h1000_0000);
        chk("mr_f0_cnt", fcnt, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
